instr_stream_loader: RTL
========================

# instr_stream_loader

CPU-side receiver for the byte-serial instruction load stream that the bench drives on `instr_i`. After reset it captures exactly `4*WORDS` bytes, one per clock, assembles them MSB-first into 32-bit instruction words and writes each word into instruction memory through a single-cycle write strobe. When the last word is committed it raises `load_done`, which releases the pipeline's PC. It also keeps a running XOR checksum of the accepted bytes so the bench can confirm the load.

## Interface
- `WORDS`, 64, number of 32-bit instruction words per load.
- `ADDR_W`, 6, instruction-memory word-address width; must satisfy 2^ADDR_W >= WORDS.

- `sys_clk`  in  1  rising-edge clock.
- `sys_reset`  in  1  reset, synchronous and active-high.
- `instr_i`  in  8  instruction byte stream, one byte per clock, no valid qualifier.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_waddr`  out  ADDR_W  word address for `imem_wdata`.
- `imem_wdata`  out  32  assembled instruction word.
- `load_done`  out  1  load complete / CPU run enable; stays high until reset.
- `word_cnt`  out  ADDR_W+1  number of words written so far.
- `chk_o`  out  8  XOR of all accepted bytes.

## Operation
- States: LOAD and DONE. Reset, including reset asserted while in DONE, forces LOAD on the next edge.
- Load cycle n (n = 0, 1, …) is the n-th rising edge at which `sys_reset` is low while the block is in LOAD.
- Cycles during reset:
  - `instr_i` is ignored.
  - Bytes are not counted and not folded into `chk_o`.
- At load cycle n the byte on `instr_i` belongs to word w = n/4, lane l = n%4:
  - l=0 → bits [31:24], l=1 → [23:16], l=2 → [15:8], l=3 → [7:0].
  - Every accepted byte is XORed into `chk_o` at that edge.
- At the lane-3 edge of word w (n = 4w+3):
  - `imem_wdata` is loaded with the complete word, `imem_waddr` with w, and `imem_we` is set to 1.
  - `imem_we` clears at the next edge unless a new word completes there (it cannot, so it is always a single-cycle pulse).
  - `word_cnt` increments at the same edge that sets `imem_we`.
- Word assembly uses a 24-bit staging register for lanes 0–2; the lane-3 byte is merged directly into `imem_wdata`.
- At edge n = 4*WORDS, LOAD → DONE and `load_done` goes to 1. That is exactly one cycle after the final `imem_we` assertion, so the last write has been committed by the memory at that same edge.
- In DONE:
  - `imem_we` stays 0.
  - `instr_i` is ignored: trailing padding bytes do not change `chk_o`, `word_cnt` or memory.
  - `imem_waddr` and `imem_wdata` hold their last values.
- Reset mid-load:
  - Byte counter, staging register, `word_cnt` and `chk_o` clear.
  - Any partial word is discarded and never written.
  - Memory contents are not touched.
  - The next accepted byte is lane 0 of word 0.
- Counter widths: byte counter is ADDR_W+2 bits and never wraps; it saturates into DONE.

## Timing
- Reset values (after the first edge with `sys_reset`=1): `imem_we`=0, `imem_waddr`=0, `imem_wdata`=0, `load_done`=0, `word_cnt`=0, `chk_o`=0, state LOAD.
- Byte-to-write latency: the lane-3 byte is sampled at edge 4w+3, and the `imem_we`/`imem_wdata` outputs update at that same edge, i.e. they are registered outputs valid in the following cycle.
- Write cadence: `imem_we` is high for 1 cycle in every 4, with the first pulse following load cycle 3.
- Total load: `load_done` rises 4*WORDS+1 edges after reset release.
- `instr_i` must be stable around each rising edge. The bench changes it 5 ns after the edge (20 ns period), which meets this.

## Test plan
- **Incrementing stream:** reset 1 cycle, then bytes 0x00..0xFF → 64 `imem_we` pulses spaced 4 cycles apart:
  - addr 0 data 0x00010203, addr 63 data 0xFCFDFEFF.
  - `load_done`=1 one cycle after the last pulse; `word_cnt`=64, `chk_o`=0x00.
- **Single nonzero byte:** all zero bytes except 0x5A at index 10 → word 2 = 0x00005A00, all other words 0, `chk_o`=0x5A.
- **Trailing bytes:** after the 256 bytes, drive byte 256 = 0xAA and then random bytes → no `imem_we`, `chk_o` and `word_cnt` unchanged, `load_done` stays 1.
- **Reset mid-load:** assert reset for 1 cycle at load cycle 37 → no write for partial word 9. The next pulse has addr 0 and data formed from the 4 bytes following reset release; `word_cnt` restarts at 0.
- **Bytes during reset:** hold reset for 5 cycles while driving 0xFF → those bytes are not accepted; word 0 is built from the first 4 bytes after release and `chk_o` excludes the 0xFF bytes.
- **Reload after done:** assert reset while in DONE → `load_done` reads 0 after that edge, and a second full 256-byte stream reloads memory identically.

Source files
------------

// File: rtl/instr_stream_loader.sv
// Purpose : receives the byte-serial instruction load stream, packs it MSB-first into
//           32-bit words, writes each word to instruction memory, then enables the CPU.
// Latency : a word is written from registered outputs in the cycle after its lane-3 byte
//           is sampled. load_done rises 4*WORDS+1 edges after reset release.
// Backpressure: none. One byte is consumed every cycle while loading, and bytes are
//           ignored once the load is done.
//
// Ports:
//   sys_clk, sys_reset   rising-edge clock, synchronous active-high reset
//   instr_i              load byte, one per clock, no qualifier
//   imem_we/waddr/wdata  single-cycle instruction-memory write port
//   load_done            load complete, CPU run enable, held until reset
//   word_cnt             words written so far
//   chk_o                XOR of every accepted byte
module instr_stream_loader #(
  parameter int WORDS  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              sys_clk,
  input  logic              sys_reset,
  input  logic [7:0]        instr_i,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              load_done,
  output logic [ADDR_W:0]   word_cnt,
  output logic [7:0]        chk_o
);

  // Byte counter: upper bits give the word index and the low two bits give the lane.
  localparam int                BCNT_W     = ADDR_W + 2;
  localparam logic [BCNT_W-1:0] LAST_BYTE  = BCNT_W'(4 * WORDS - 1);
  localparam logic [ADDR_W:0]   WORD_TOTAL = (ADDR_W + 1)'(WORDS);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t            state;
  logic [BCNT_W-1:0] byte_cnt;
  logic [23:0]       stage;     // lanes 0..2 of the word being built
  logic [1:0]        lane;

  assign lane = byte_cnt[1:0];

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state      <= ST_LOAD;
      byte_cnt   <= '0;
      stage      <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      load_done  <= 1'b0;
      word_cnt   <= '0;
      chk_o      <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (word_cnt == WORD_TOTAL) begin
            // The edge after the final write. The memory commits that write
            // on this same edge, so releasing the PC here is safe. The byte
            // on instr_i at this edge is padding and is not accepted.
            state     <= ST_DONE;
            load_done <= 1'b1;
            imem_we   <= 1'b0;
          end else begin
            chk_o <= chk_o ^ instr_i;
            // Hold the counter on the last byte instead of wrapping. word_cnt
            // reaching WORDS is what moves the block into DONE.
            if (byte_cnt != LAST_BYTE) begin
              byte_cnt <= byte_cnt + 1'b1;
            end
            case (lane)
              2'd0: begin
                stage[23:16] <= instr_i;
                imem_we      <= 1'b0;
              end
              2'd1: begin
                stage[15:8] <= instr_i;
                imem_we     <= 1'b0;
              end
              2'd2: begin
                stage[7:0] <= instr_i;
                imem_we    <= 1'b0;
              end
              default: begin
                // The lane-3 byte bypasses staging and completes the word directly.
                imem_wdata <= {stage, instr_i};
                imem_waddr <= byte_cnt[BCNT_W-1:2];
                imem_we    <= 1'b1;
                word_cnt   <= word_cnt + 1'b1;
              end
            endcase
          end
        end
        ST_DONE: begin
          // Address and data hold their last values. Padding bytes are ignored.
          imem_we <= 1'b0;
        end
        default: begin
          state   <= ST_LOAD;
          imem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule
